sid_reg_player: RTL and testbench

Register-write initiator for the SID register bus: accepts timed write commands (delay, address, data) on a valid/ready stream, buffers them in a FIFO, and replays each as a single-cycle `WR` pulse with `ADDR`/`DATA` after the commanded number of `CLKen` (1 MHz) ticks. It drives the same `WR`/`ADDR`/`DATA` bus consumed by `sid_voice` and the other register decoders. It sits between a host/SPI/ROM command source and the SID core, providing cycle-accurate tune playback.

---
 rtl/sid_pkg.sv | 46 ++++
 rtl/sid_cmd_fifo.sv | 61 ++++++
 rtl/sid_reg_player.sv | 126 ++++++++++++
 tb/tb_sid_reg_player.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sid_pkg.sv
// Shared types and constants for the SID register-bus player and its decoders.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sid_pkg;

  // Player sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WRITE = 2'd2
  } sid_state_e;

  // Size of the SID register map (voice 1..3, filter, volume)
  localparam int SID_NUM_REGS = 25;

  // Per-voice register offsets (voice 1 base)
  localparam logic [4:0] FREQ_LO = 5'd0;
  localparam logic [4:0] FREQ_HI = 5'd1;
  localparam logic [4:0] PW_LO   = 5'd2;
  localparam logic [4:0] PW_HI   = 5'd3;
  localparam logic [4:0] CTRL    = 5'd4;
  localparam logic [4:0] ATK_DEC = 5'd5;
  localparam logic [4:0] SUS_REL = 5'd6;
  localparam logic [4:0] MODE_VOL = 5'd24;

  // One register write on the bus
  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } sid_wr_t;

  localparam int SID_WR_W = $bits(sid_wr_t);

  // Timed command at the default delay width; wider players pack the delay ahead of sid_wr_t the same way
  localparam int SID_DLY_W = 16;
  typedef struct packed {
    logic [SID_DLY_W-1:0] dly;
    sid_wr_t              wr;
  } sid_cmd_t;

  // True when the address maps onto a real SID register
  function automatic logic sid_is_reg(input logic [4:0] addr);
    return (addr < 5'(SID_NUM_REGS));
  endfunction

endpackage

// File: rtl/sid_cmd_fifo.sv
// Synchronous FIFO with registered occupancy count for timed SID commands.
// Latency: pushed entry is visible at the head the cycle after the push edge.
// Backpressure: push_rdy_o is registered "not full"; a push while full is dropped even if a pop coincides.
module sid_cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_vld_i,
  input  logic [W-1:0]             push_dat_i,
  output logic                     push_rdy_o,
  input  logic                     pop_i,
  output logic [W-1:0]             head_dat_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          rdy_q;
  logic          push;
  logic          pop;

  assign push       = push_vld_i && rdy_q;
  assign pop        = pop_i && (count_q != '0);
  assign head_dat_o = mem_q[rd_ptr_q];
  assign push_rdy_o = rdy_q;
  assign count_o    = count_q;

  // Next occupancy: push and pop together leave it unchanged
  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Pointers, count and the registered ready flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdy_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      rdy_q   <= (count_d != CW'(DEPTH));
    end
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/sid_reg_player.sv
// Replays buffered {delay, addr, data} commands as one-cycle WR strobes after delay CLKen ticks; optional SID_PLAYER_SHADOW_EN adds a readable 25x8 shadow of written registers.
// Latency: push-to-WR is 2 CLK for delay 0; otherwise WR follows the N-th CLKen after the pop by one CLK.
// Backpressure: IN_READY is registered "FIFO not full"; writes on the bus are never stalled.
module sid_reg_player
  import sid_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int WAIT_W = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CLKen,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [WAIT_W-1:0]        IN_WAIT,
  input  logic [4:0]               IN_ADDR,
  input  logic [7:0]               IN_DATA,
`ifdef SID_PLAYER_SHADOW_EN
  input  logic [4:0]               SHADOW_ADDR,
  output logic [7:0]               SHADOW_DATA,
`endif
  output logic                     WR,
  output logic [4:0]               ADDR,
  output logic [7:0]               DATA,
  output logic                     BUSY,
  output logic [$clog2(DEPTH):0]   LEVEL
);

  localparam int CMD_W = WAIT_W + SID_WR_W;

  logic [CMD_W-1:0]  push_dat;
  logic [CMD_W-1:0]  head_dat;
  logic [WAIT_W-1:0] head_dly;
  sid_wr_t           head_wr;
  logic [$clog2(DEPTH):0] fifo_count;
  logic              fifo_empty;

  sid_state_e        state_q;
  logic [WAIT_W-1:0] cnt_q;
  sid_wr_t           pend_q;
  sid_wr_t           bus_q;
  logic              wr_q;

  assign push_dat            = {IN_WAIT, IN_ADDR, IN_DATA};
  assign {head_dly, head_wr} = head_dat;
  assign fifo_empty          = (fifo_count == '0);

  sid_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk_i      (CLK),
    .rst_i      (RST),
    .push_vld_i (IN_VALID),
    .push_dat_i (push_dat),
    .push_rdy_o (IN_READY),
    .pop_i      (state_q == ST_IDLE),
    .head_dat_o (head_dat),
    .count_o    (fifo_count)
  );

  // Sequencer: pop in IDLE, count CLKen ticks in WAIT, strobe for one cycle in WRITE
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      bus_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            cnt_q  <= head_dly;
            pend_q <= head_wr;
            if (head_dly == '0) begin
              state_q <= ST_WRITE;
              wr_q    <= 1'b1;
              bus_q   <= head_wr;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (CLKen) begin
            cnt_q <= cnt_q - WAIT_W'(1);
            if (cnt_q == WAIT_W'(1)) begin
              state_q <= ST_WRITE;
              wr_q    <= 1'b1;
              bus_q   <= pend_q;
            end
          end
        end
        ST_WRITE: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign WR    = wr_q;
  assign ADDR  = bus_q.addr;
  assign DATA  = bus_q.data;
  assign BUSY  = (state_q != ST_IDLE) || !fifo_empty;
  assign LEVEL = fifo_count;

`ifdef SID_PLAYER_SHADOW_EN
  logic [7:0] shadow_q [SID_NUM_REGS];
  logic [7:0] shadow_rd_q;

  // Shadow copy of every strobed write; the read register samples before the write lands
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < SID_NUM_REGS; i++) shadow_q[i] <= '0;
      shadow_rd_q <= '0;
    end else begin
      if (wr_q && sid_is_reg(bus_q.addr)) shadow_q[bus_q.addr] <= bus_q.data;
      shadow_rd_q <= sid_is_reg(SHADOW_ADDR) ? shadow_q[SHADOW_ADDR] : '0;
    end
  end

  assign SHADOW_DATA = shadow_rd_q;
`endif

endmodule

// File: tb/tb_sid_reg_player.sv
// Bench for sid_reg_player: directed scenarios plus randomized traffic against a queue-based model.
// Latency: model predicts every output for the cycle after each CLK edge.
// Backpressure: model tracks FIFO fullness itself and drops pushes while full.
module tb_sid_reg_player;

  localparam int DEPTH  = 16;
  localparam int WAIT_W = 16;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic CLK = 1'b0;
  logic RST, CLKen, IN_VALID, IN_READY;
  logic [WAIT_W-1:0] IN_WAIT;
  logic [4:0] IN_ADDR, ADDR;
  logic [7:0] IN_DATA, DATA;
  logic WR, BUSY;
  logic [LW-1:0] LEVEL;
`ifdef SID_PLAYER_SHADOW_EN
  logic [4:0] shadow_addr;
  logic [7:0] shadow_data;
  logic [7:0] sh_m [25];
`endif

  int n_vec = 0;
  int n_err = 0;
  int ck_mode = 0;

  sid_reg_player #(.DEPTH(DEPTH), .WAIT_W(WAIT_W)) dut (
    .CLK(CLK), .RST(RST), .CLKen(CLKen), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_WAIT(IN_WAIT), .IN_ADDR(IN_ADDR), .IN_DATA(IN_DATA),
`ifdef SID_PLAYER_SHADOW_EN
    .SHADOW_ADDR(shadow_addr), .SHADOW_DATA(shadow_data),
`endif
    .WR(WR), .ADDR(ADDR), .DATA(DATA), .BUSY(BUSY), .LEVEL(LEVEL)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int unsigned dly;
    logic [4:0]  a;
    logic [7:0]  d;
  } mcmd_t;

  mcmd_t mq[$];
  mcmd_t cur;
  int    ph = 0;          // 0 nothing in flight, 1 counting ticks, 2 strobe showing
  int    seen = 0;
  logic  m_wr = 1'b0;
  logic [4:0] m_addr = '0;
  logic [7:0] m_data = '0;
  int    m_level = 0;
  bit    m_ready = 1'b0;
  bit    m_busy = 1'b0;
  bit    m_acc;
  bit    chk_en = 1'b0;

  always @(posedge CLK) begin
    if (RST) begin
      mq.delete();
      ph = 0; m_wr = 1'b0; m_addr = '0; m_data = '0;
      m_level = 0; m_ready = 1'b0; m_busy = 1'b0;
      chk_en = 1'b1;
    end else begin
      m_acc = IN_VALID && m_ready;
      m_wr  = 1'b0;
      if (ph == 2) begin
        ph = 0;
      end else if (ph == 1) begin
        if (CLKen) begin
          seen++;
          if (seen == int'(cur.dly)) begin
            m_wr = 1'b1; m_addr = cur.a; m_data = cur.d; ph = 2;
          end
        end
      end else if (mq.size() > 0) begin
        cur = mq.pop_front();
        if (cur.dly == 0) begin
          m_wr = 1'b1; m_addr = cur.a; m_data = cur.d; ph = 2;
        end else begin
          ph = 1; seen = 0;
        end
      end
      if (m_acc) mq.push_back('{32'(IN_WAIT), IN_ADDR, IN_DATA});
      m_level = mq.size();
      m_ready = (m_level < DEPTH);
      m_busy  = (ph != 0) || (m_level != 0);
    end
  end

  // Every-cycle comparison against the model
  always @(negedge CLK) begin
    if (chk_en) begin
      check("WR",       32'(WR),       32'(m_wr));
      check("ADDR",     32'(ADDR),     32'(m_addr));
      check("DATA",     32'(DATA),     32'(m_data));
      check("BUSY",     32'(BUSY),     32'(m_busy));
      check("LEVEL",    32'(LEVEL),    32'(m_level));
      check("IN_READY", 32'(IN_READY), 32'(m_ready));
    end
  end

  // ---------------- write log ----------------
  typedef struct {
    int         cyc;
    int         ticks;
    bit         ck;
    logic [4:0] a;
    logic [7:0] d;
  } wlog_t;

  wlog_t wlog[$];
  int cyc = 0;
  int ticks = 0;
  bit prev_ck = 1'b0;

  always @(posedge CLK) begin
    if (WR === 1'b1) wlog.push_back('{cyc, ticks, prev_ck, ADDR, DATA});
    prev_ck = CLKen && !RST;
    if (CLKen && !RST) ticks++;
    cyc++;
  end

  // ---------------- CLKen generator ----------------
  int c16 = 0;
  initial begin
    CLKen = 1'b0;
    forever begin
      @(negedge CLK);
      case (ck_mode)
        1: begin c16 = (c16 + 1) % 16; CLKen = (c16 == 0); end
        2: CLKen = ($urandom_range(3, 0) == 0);
        default: CLKen = 1'b0;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic push(input logic [WAIT_W-1:0] w, input logic [4:0] a, input logic [7:0] d);
    int n = 0;
    IN_VALID = 1'b1; IN_WAIT = w; IN_ADDR = a; IN_DATA = d;
    while (!IN_READY && n < 200) begin tick(); n++; end
    if (!IN_READY) check("push_timeout", 32'(n), 32'(0));
    tick();
    IN_VALID = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (BUSY && n < 3000) begin tick(); n++; end
    check("drain_idle", 32'(BUSY), 32'(0));
  endtask

  task automatic wait_log(input int want, input int budget);
    int n = 0;
    while (wlog.size() < want && n < budget) begin tick(); n++; end
    check("log_count", 32'(wlog.size()), 32'(want));
  endtask

  int t0;
  int acc;

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; IN_WAIT = '0; IN_ADDR = '0; IN_DATA = '0;
`ifdef SID_PLAYER_SHADOW_EN
    shadow_addr = '0;
`endif
    repeat (3) tick();

    // Reset values
    check("rst_WR",    32'(WR),       32'(0));
    check("rst_ADDR",  32'(ADDR),     32'(0));
    check("rst_DATA",  32'(DATA),     32'(0));
    check("rst_BUSY",  32'(BUSY),     32'(0));
    check("rst_LEVEL", 32'(LEVEL),    32'(0));
    check("rst_READY", 32'(IN_READY), 32'(0));
    RST = 1'b0;
    tick();
    check("ready_after_rst", 32'(IN_READY), 32'(1));

    // Single zero-delay write: strobe in the second cycle after the push edge
    push(16'd0, 5'h04, 8'h11);
    check("t1_wr_early", 32'(WR), 32'(0));
    tick();
    check("t1_wr",   32'(WR),   32'(1));
    check("t1_addr", 32'(ADDR), 32'h04);
    check("t1_data", 32'(DATA), 32'h11);
    tick();
    check("t1_wr_off", 32'(WR),   32'(0));
    check("t1_busy",   32'(BUSY), 32'(0));
    check("t1_hold",   32'(DATA), 32'h11);

    // Ten back-to-back zero-delay writes, two cycles apart, in order
    wlog.delete();
    for (int i = 0; i < 10; i++) push(16'd0, 5'(i), 8'(8'hA0 + i));
    wait_log(10, 100);
    for (int i = 0; i < 10 && i < wlog.size(); i++) begin
      check("b2b_data", 32'(wlog[i].d), 32'(8'hA0 + i));
      check("b2b_addr", 32'(wlog[i].a), 32'(i));
      if (i > 0) check("b2b_gap", 32'(wlog[i].cyc - wlog[i-1].cyc), 32'(2));
    end
    drain();

    // Tick-delayed writes with CLKen every 16 CLK
    ck_mode = 1;
    for (int n = 0; n < 40 && CLKen !== 1'b1; n++) tick();
    tick();
    t0 = ticks;
    wlog.delete();
    push(16'd3, 5'h01, 8'h44);
    push(16'd2, 5'h00, 8'h95);
    wait_log(2, 200);
    if (wlog.size() >= 2) begin
      check("tk_data0",  32'(wlog[0].d), 32'h44);
      check("tk_ticks0", 32'(wlog[0].ticks - t0), 32'(3));
      check("tk_ck0",    32'(wlog[0].ck), 32'(1));
      check("tk_data1",  32'(wlog[1].d), 32'h95);
      check("tk_ticks1", 32'(wlog[1].ticks - wlog[0].ticks), 32'(2));
      check("tk_ck1",    32'(wlog[1].ck), 32'(1));
    end
    drain();
    ck_mode = 0;
    tick(); tick();

    // Overflow: CLKen idle, long delays, offer DEPTH+3 pushes
    acc = 0;
    IN_VALID = 1'b1; IN_WAIT = 16'd1000; IN_DATA = 8'h5A;
    for (int i = 0; i < DEPTH + 3; i++) begin
      IN_ADDR = 5'(i);
      if (IN_READY) acc++;
      tick();
    end
    IN_VALID = 1'b0;
    check("ovf_accepted", 32'(acc),      32'(DEPTH + 1));
    check("ovf_level",    32'(LEVEL),    32'(DEPTH));
    check("ovf_ready",    32'(IN_READY), 32'(0));
    tick();
    check("ovf_level_hold", 32'(LEVEL), 32'(DEPTH));
    RST = 1'b1; tick(); RST = 1'b0; tick();

    // Reset while waiting with five queued: nothing is ever written
    for (int i = 0; i < 6; i++) push(16'd20, 5'(i), 8'(i));
    tick();
    check("rw_level", 32'(LEVEL), 32'(5));
    check("rw_busy",  32'(BUSY),  32'(1));
    ck_mode = 2;
    repeat (5) tick();
    wlog.delete();
    RST = 1'b1; tick(); RST = 1'b0; tick();
    check("rw_level0", 32'(LEVEL),    32'(0));
    check("rw_busy0",  32'(BUSY),     32'(0));
    check("rw_ready",  32'(IN_READY), 32'(1));
    repeat (200) tick();
    check("rw_no_wr", 32'(wlog.size()), 32'(0));
    ck_mode = 0;

`ifdef SID_PLAYER_SHADOW_EN
    // Shadow file: readback after a write, and an out-of-map write changes nothing
    for (int i = 0; i < 25; i++) sh_m[i] = 8'h00;
    RST = 1'b1; tick(); RST = 1'b0; tick();
    push(16'd0, 5'h18, 8'h0F);
    sh_m[24] = 8'h0F;
    drain();
    shadow_addr = 5'h18;
    tick();
    check("sh_read", 32'(shadow_data), 32'h0F);
    push(16'd0, 5'h1F, 8'hAA);
    drain();
    for (int i = 0; i < 25; i++) begin
      shadow_addr = 5'(i);
      tick();
      check("sh_entry", 32'(shadow_data), 32'(sh_m[i]));
    end
`endif

    // Randomized traffic against the model
    ck_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      IN_VALID = ($urandom_range(1, 0) == 1);
      IN_WAIT  = ($urandom_range(3, 0) == 0) ? 16'd0 : 16'($urandom_range(8, 1));
      IN_ADDR  = 5'($urandom_range(31, 0));
      IN_DATA  = 8'($urandom_range(255, 0));
      RST      = ($urandom_range(499, 0) == 0);
      tick();
    end
    IN_VALID = 1'b0;
    RST = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
